instr_fetch: RTL and testbench

Program-counter and instruction-fetch stage of KGP_RISC, sitting directly upstream of branch_mechanism. Holds the PC and fetches each instruction from instruction memory over a req/ack handshake. Presents the fetched instruction, its address (pda) and pda+4 (instr4) to decode/execute and branch_mechanism. Loads the PC from branch_mechanism's nextInstr once the current instruction retires.

---
 rtl/kgp_risc_pkg.sv | 9 +
 rtl/fetch_timeout_ctr.sv | 19 +
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared fetch-stage state encodings and datapath constants.
package kgp_risc_pkg;
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: cycles spent waiting for imem_ack; o_tc marks the last allowed cycle.
module fetch_timeout_ctr
    import kgp_risc_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tc
);
    localparam int W = $clog2(IMEM_TIMEOUT + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else      r_cnt <= i_clr ? '0 : r_cnt + W'(1);
    end
    assign o_tc = r_cnt == W'(IMEM_TIMEOUT - 1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: KGP_RISC PC register and req/ack instruction fetch stage.
// Optional FETCH_MISALIGN_CHECK_EN faults on branch targets not word-aligned.
module instr_fetch
    import kgp_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nextInstr,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pda,
    output logic [31:0] instr4,
    output logic [31:0] retired,
    output logic        fault
);
    logic [1:0]  r_state;
    logic        r_started;
    logic [31:0] r_pda;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_retired;
    logic        r_fault;
    logic        w_fetching;
    logic        w_tc;
    logic        w_misalign;
    logic [31:0] w_next_pc;

    // Reset parks in FETCH with the request held off until the first edge after release.
    assign w_fetching  = r_started && r_state == FETCH;
    assign imem_req    = w_fetching;
    assign imem_addr   = r_pda;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pda         = r_pda;
    assign instr4      = r_pda + PC_INC;
    assign retired     = r_retired;
    assign fault       = r_fault;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misalign = nextInstr[1:0] != 2'b00;
    assign w_next_pc  = nextInstr;
`else
    assign w_misalign = 1'b0;
    assign w_next_pc  = nextInstr & 32'hFFFF_FFFC;
`endif

    fetch_timeout_ctr #(.IMEM_TIMEOUT(IMEM_TIMEOUT)) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .i_clr(!w_fetching || imem_ack),
        .o_tc (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= FETCH;
            r_started <= 1'b0;
            r_pda     <= RESET_PC;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_retired <= '0;
            r_fault   <= 1'b0;
        end else if (!r_started) begin
            r_started <= 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_valid <= 1'b1;
                        r_state <= EXEC;
                    end else if (w_tc) begin
                        r_fault <= 1'b1;
                        r_state <= FAULT;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        r_retired <= r_retired + 32'd1;
                        r_valid   <= 1'b0;
                        if (halt) begin
                            r_state <= HALTED;
                        end else if (w_misalign) begin
                            r_fault <= 1'b1;
                            r_state <= FAULT;
                        end else begin
                            r_pda   <= w_next_pc;
                            r_state <= FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch reset, flow, branch, stall, halt, timeout.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] nextInstr = '0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pda;
    logic [31:0] instr4;
    logic [31:0] retired;
    logic        fault;
    int total = 0;
    int bad = 0;

    instr_fetch #(.RESET_PC(32'h0), .IMEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .nextInstr(nextInstr), .stall(stall), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .pda(pda), .instr4(instr4),
        .retired(retired), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; imem_ack = 1'b0; stall = 1'b0; halt = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic fetch_ack(input logic [31:0] d);
        imem_ack = 1'b1; imem_data = d;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_ack = 1'b1;
        step(); step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (pda !== 32'h0) begin bad++; $display("FAIL rst_pda got=%h exp=0", pda); end
        total++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr got=%h/%b exp=0/0", instr, instr_valid); end
        total++; if (retired !== 32'h0 || fault !== 1'b0) begin bad++; $display("FAIL rst_cnt got=%h/%b exp=0/0", retired, fault); end
        imem_ack = 1'b0; rst = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
        fetch_ack(32'h0003_0005);
        total++; if (instr !== 32'h0003_0005 || instr_valid !== 1'b1) begin bad++; $display("FAIL first_instr got=%h/%b exp=00030005/1", instr, instr_valid); end
        total++; if (pda !== 32'h0 || instr4 !== 32'h4) begin bad++; $display("FAIL first_pc got=%h/%h exp=0/4", pda, instr4); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL exec_req got=%b exp=0", imem_req); end
    endtask

    task automatic test_sequential();
        nextInstr = 32'h4; step();
        total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL seq_fetch4 got=%h/%b/%b exp=4/1/0", imem_addr, imem_req, instr_valid); end
        fetch_ack(32'h1111_1111);
        total++; if (pda !== 32'h4) begin bad++; $display("FAIL seq_pda4 got=%h exp=4", pda); end
        nextInstr = 32'h8; step();
        fetch_ack(32'h2222_2222);
        total++; if (pda !== 32'h8 || instr !== 32'h2222_2222) begin bad++; $display("FAIL seq_pda8 got=%h/%h exp=8/22222222", pda, instr); end
        nextInstr = 32'hC; step();
        total++; if (retired !== 32'd3 || imem_addr !== 32'hC) begin bad++; $display("FAIL seq_retired got=%0d/%h exp=3/c", retired, imem_addr); end
        fetch_ack(32'h3333_3333);
    endtask

    task automatic test_branch();
        nextInstr = 32'h0000_0880; step();
        total++; if (imem_addr !== 32'h0000_0880 || imem_req !== 1'b1) begin bad++; $display("FAIL br_addr got=%h/%b exp=880/1", imem_addr, imem_req); end
        total++; if (instr4 !== 32'h0000_0884) begin bad++; $display("FAIL br_instr4 got=%h exp=884", instr4); end
        fetch_ack(32'hABCD_0001);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextInstr = i[0] ? 32'h100 : 32'h200;
            imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
            step();
            total++; if (pda !== 32'h880 || instr !== 32'hABCD_0001 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%b/%b exp=880/abcd0001/0/1", i, pda, instr, imem_req, instr_valid); end
        end
        imem_ack = 1'b0; stall = 1'b0; nextInstr = 32'h300;
        step();
        total++; if (pda !== 32'h300 || imem_req !== 1'b1 || retired !== 32'd5) begin bad++; $display("FAIL stall_release got=%h/%b/%0d exp=300/1/5", pda, imem_req, retired); end
        fetch_ack(32'h0000_0777);
    endtask

    task automatic test_halt();
        halt = 1'b1; nextInstr = 32'h500;
        step();
        halt = 1'b0; imem_ack = 1'b1; imem_data = 32'h9999_9999;
        total++; if (retired !== 32'd6 || instr_valid !== 1'b0 || pda !== 32'h300) begin bad++; $display("FAIL halt_state got=%0d/%b/%h exp=6/0/300", retired, instr_valid, pda); end
        step(); step(); step();
        total++; if (imem_req !== 1'b0 || instr !== 32'h0000_0777 || retired !== 32'd6) begin bad++; $display("FAIL halt_sticky got=%b/%h/%0d exp=0/777/6", imem_req, instr, retired); end
        imem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        fetch_ack(32'h1);
        nextInstr = 32'hFFFF_FFFC; step();
        total++; if (pda !== 32'hFFFF_FFFC || instr4 !== 32'h0) begin bad++; $display("FAIL wrap_instr4 got=%h/%h exp=fffffffc/0", pda, instr4); end
    endtask

    task automatic test_misalign();
        do_reset();
        fetch_ack(32'h5);
        nextInstr = 32'h0000_0006; step();
`ifdef FETCH_MISALIGN_CHECK_EN
        total++; if (fault !== 1'b1 || imem_req !== 1'b0 || pda !== 32'h0 || retired !== 32'd1) begin bad++; $display("FAIL misalign got=%b/%b/%h/%0d exp=1/0/0/1", fault, imem_req, pda, retired); end
`else
        total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL misalign got=%h/%b/%b exp=4/1/0", imem_addr, imem_req, fault); end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 15; i++) step();
        total++; if (fault !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL to_last_ok got=%b/%b exp=0/1", fault, imem_req); end
        fetch_ack(32'h4242_4242);
        total++; if (instr_valid !== 1'b1 || instr !== 32'h4242_4242 || fault !== 1'b0) begin bad++; $display("FAIL to_late_ack got=%b/%h/%b exp=1/42424242/0", instr_valid, instr, fault); end
        do_reset();
        for (int i = 0; i < 15; i++) step();
        step();
        total++; if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL to_fault got=%b/%b/%b exp=1/0/0", fault, imem_req, instr_valid); end
        step(); step();
        total++; if (fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b exp=1/0", fault, imem_req); end
        imem_ack = 1'b1; imem_data = 32'h5555_5555;
        #2 rst = 1'b0;
        #1;
        total++; if (fault !== 1'b0 || pda !== 32'h0 || retired !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL async_rst got=%b/%h/%h/%h/%b exp=0/0/0/0/0", fault, pda, retired, instr, imem_req); end
        step();
        total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL rst_ack_drop got=%b/%h/%b exp=0/0/0", instr_valid, instr, imem_req); end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        step(); step();
        imem_ack = 1'b1; imem_data = 32'h6666_6666;
        rst = 1'b0;
        step();
        total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL mid_rst got=%b/%h/%b exp=0/0/0", instr_valid, instr, imem_req); end
        imem_ack = 1'b0; rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_halt();
        test_wrap();
        test_misalign();
        test_timeout();
        test_reset_mid_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
